// File: rtl/pito_dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the single memory port.
// Handshake: a requester holds req/we/be/addr/wdata until it sees gnt in the same cycle (zero-latency accept); dropping req before gnt abandons it; a read returns rvalid/rdata exactly one cycle after its gnt.
interface pito_dmem_arbiter_if #(
  parameter int DMEM_ADDR_W = 12,
  parameter int DATA_W      = 32
);
  logic                   pito_program;

  logic                   c_req;
  logic                   c_we;
  logic [DATA_W/8-1:0]    c_be;
  logic [DMEM_ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0]      c_wdata;
  logic                   c_gnt;
  logic                   c_rvalid;
  logic [DATA_W-1:0]      c_rdata;
  logic [3:0]             c_wait_cnt;

  logic                   e_req;
  logic                   e_we;
  logic [DATA_W/8-1:0]    e_be;
  logic [DMEM_ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0]      e_wdata;
  logic                   e_gnt;
  logic                   e_rvalid;
  logic [DATA_W-1:0]      e_rdata;

  logic                   mem_req;
  logic                   mem_we;
  logic [DATA_W/8-1:0]    mem_be;
  logic [DMEM_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  // Requesters and memory model side.
  modport master (
    output pito_program,
    output c_req, c_we, c_be, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata, c_wait_cnt,
    output e_req, e_we, e_be, e_addr, e_wdata,
    input  e_gnt, e_rvalid, e_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

  // Arbiter side.
  modport slave (
    input  pito_program,
    input  c_req, c_we, c_be, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata, c_wait_cnt,
    input  e_req, e_we, e_be, e_addr, e_wdata,
    output e_gnt, e_rvalid, e_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/pito_dmem_arbiter.sv
// Arbitrates the pito core data port (0) and the external host port (1) onto one data-memory port.
// Fixed ext priority in program mode, round-robin otherwise; read data is steered back one cycle later.
module pito_dmem_arbiter (
  input  logic                 clk,
  input  logic                 rst_n,
  pito_dmem_arbiter_if.slave   bus,
  output logic                 dbg_last_gnt_o,
  output logic                 dbg_rd_pend_o
);

  logic       last_gnt_q, last_gnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_id_q, rd_id_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;

  logic c_req_ok, e_req_ok;
  logic c_gnt, e_gnt;

  // Requests are ignored while in reset so no strobe escapes to memory.
  assign c_req_ok = rst_n & bus.c_req;
  assign e_req_ok = rst_n & bus.e_req;

  always_comb begin
    c_gnt = 1'b0;
    e_gnt = 1'b0;
    if (bus.pito_program) begin
      e_gnt = e_req_ok;
    end else if (c_req_ok && e_req_ok) begin
      c_gnt = last_gnt_q;
      e_gnt = ~last_gnt_q;
    end else begin
      c_gnt = c_req_ok;
      e_gnt = e_req_ok;
    end
  end

  assign bus.c_gnt   = c_gnt;
  assign bus.e_gnt   = e_gnt;
  assign bus.mem_req = c_gnt | e_gnt;

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (c_gnt) begin
      bus.mem_we    = bus.c_we;
      bus.mem_be    = bus.c_be;
      bus.mem_addr  = bus.c_addr;
      bus.mem_wdata = bus.c_wdata;
    end else if (e_gnt) begin
      bus.mem_we    = bus.e_we;
      bus.mem_be    = bus.e_be;
      bus.mem_addr  = bus.e_addr;
      bus.mem_wdata = bus.e_wdata;
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    rd_id_d    = rd_id_q;
    if (c_gnt) begin
      last_gnt_d = 1'b0;
      rd_id_d    = 1'b0;
    end else if (e_gnt) begin
      last_gnt_d = 1'b1;
      rd_id_d    = 1'b1;
    end
    rd_pend_d = (c_gnt | e_gnt) & ~bus.mem_we;
  end

  // Diagnostic wait counter: holds while program mode starves the core.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.c_req || c_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (!bus.pito_program && wait_cnt_q != 4'd15) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_id_q    <= 1'b0;
      wait_cnt_q <= 4'd0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_id_q    <= rd_id_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign bus.c_rvalid   = rd_pend_q & ~rd_id_q;
  assign bus.e_rvalid   = rd_pend_q & rd_id_q;
  assign bus.c_rdata    = bus.c_rvalid ? bus.mem_rdata : '0;
  assign bus.e_rdata    = bus.e_rvalid ? bus.mem_rdata : '0;
  assign bus.c_wait_cnt = wait_cnt_q;

  assign dbg_last_gnt_o = last_gnt_q;
  assign dbg_rd_pend_o  = rd_pend_q;

endmodule

// File: tb/tb_pito_dmem_arbiter.sv
// Directed bench for pito_dmem_arbiter: a per-cycle vector table plus model-checked contention runs.
module tb_pito_dmem_arbiter;

  logic clk;
  logic rst_n;
  logic dbg_last_gnt;
  logic dbg_rd_pend;

  int checks = 0;
  int errors = 0;

  pito_dmem_arbiter_if #(.DMEM_ADDR_W(12), .DATA_W(32)) bus ();

  pito_dmem_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .dbg_last_gnt_o (dbg_last_gnt),
    .dbg_rd_pend_o  (dbg_rd_pend)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, prog;
    logic        cr, cw;
    logic [3:0]  cbe;
    logic [11:0] ca;
    logic [31:0] cd;
    logic        er, ew;
    logic [3:0]  ebe;
    logic [11:0] ea;
    logic [31:0] ed;
    logic [31:0] mrd;
    logic [1:0]  g;      // {c_gnt, e_gnt}
    logic        mreq, mwe;
    logic [3:0]  mbe;
    logic [11:0] maddr;
    logic [31:0] mwd;
    logic [1:0]  rv;     // {c_rvalid, e_rvalid}
    logic [31:0] crd, erd;
    logic [3:0]  wt;
    logic        lg;
  } vec_t;

  vec_t vecs[20];

  // Small reference model state for the hand-written contention runs.
  logic       m_last, m_pend, m_id;
  logic [3:0] m_wait;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.pito_program = 1'b0;
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_be = '0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.e_req = 1'b0; bus.e_we = 1'b0; bus.e_be = '0; bus.e_addr = '0; bus.e_wdata = '0;
    bus.mem_rdata = '0;
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    rst_n = ~v.rst;
    bus.pito_program = v.prog;
    bus.c_req = v.cr; bus.c_we = v.cw; bus.c_be = v.cbe; bus.c_addr = v.ca; bus.c_wdata = v.cd;
    bus.e_req = v.er; bus.e_we = v.ew; bus.e_be = v.ebe; bus.e_addr = v.ea; bus.e_wdata = v.ed;
    bus.mem_rdata = v.mrd;
    #2;
    check($sformatf("v%0d gnt", i),       {30'd0, bus.c_gnt, bus.e_gnt}, {30'd0, v.g});
    check($sformatf("v%0d mem_req", i),   {31'd0, bus.mem_req}, {31'd0, v.mreq});
    check($sformatf("v%0d mem_we", i),    {31'd0, bus.mem_we}, {31'd0, v.mwe});
    check($sformatf("v%0d mem_be", i),    {28'd0, bus.mem_be}, {28'd0, v.mbe});
    check($sformatf("v%0d mem_addr", i),  {20'd0, bus.mem_addr}, {20'd0, v.maddr});
    check($sformatf("v%0d mem_wdata", i), bus.mem_wdata, v.mwd);
    check($sformatf("v%0d rvalid", i),    {30'd0, bus.c_rvalid, bus.e_rvalid}, {30'd0, v.rv});
    check($sformatf("v%0d c_rdata", i),   bus.c_rdata, v.crd);
    check($sformatf("v%0d e_rdata", i),   bus.e_rdata, v.erd);
    check($sformatf("v%0d c_wait_cnt", i), {28'd0, bus.c_wait_cnt}, {28'd0, v.wt});
    check($sformatf("v%0d last_gnt", i),  {31'd0, dbg_last_gnt}, {31'd0, v.lg});
  endtask

  // One cycle of read traffic checked against the reference model.
  task automatic step(input string tag, input logic prog, input logic cr, input logic er);
    logic        ec, ee, exp_cv, exp_ev;
    logic [31:0] rd;
    logic [11:0] exp_addr;
    @(negedge clk);
    rd = $urandom;
    bus.pito_program = prog;
    bus.c_req = cr; bus.c_we = 1'b0; bus.c_be = 4'hF; bus.c_addr = 12'h1C0; bus.c_wdata = '0;
    bus.e_req = er; bus.e_we = 1'b0; bus.e_be = 4'hF; bus.e_addr = 12'h2E0; bus.e_wdata = '0;
    bus.mem_rdata = rd;
    if (prog) begin
      ec = 1'b0; ee = er;
    end else if (cr && er) begin
      ec = m_last; ee = ~m_last;
    end else begin
      ec = cr; ee = er;
    end
    exp_addr = ec ? 12'h1C0 : (ee ? 12'h2E0 : 12'h000);
    exp_cv = m_pend & ~m_id;
    exp_ev = m_pend & m_id;
    #2;
    check({tag, " c_gnt"},      {31'd0, bus.c_gnt}, {31'd0, ec});
    check({tag, " e_gnt"},      {31'd0, bus.e_gnt}, {31'd0, ee});
    check({tag, " mem_addr"},   {20'd0, bus.mem_addr}, {20'd0, exp_addr});
    check({tag, " c_rvalid"},   {31'd0, bus.c_rvalid}, {31'd0, exp_cv});
    check({tag, " e_rvalid"},   {31'd0, bus.e_rvalid}, {31'd0, exp_ev});
    check({tag, " c_rdata"},    bus.c_rdata, exp_cv ? rd : 32'd0);
    check({tag, " e_rdata"},    bus.e_rdata, exp_ev ? rd : 32'd0);
    check({tag, " c_wait_cnt"}, {28'd0, bus.c_wait_cnt}, {28'd0, m_wait});
    if (ec | ee) begin
      m_last = ee;
      m_id   = ee;
    end
    m_pend = ec | ee;
    if (!cr || ec)                    m_wait = 4'd0;
    else if (!prog && m_wait != 4'd15) m_wait = m_wait + 4'd1;
  endtask

  initial begin
    // rst, prog, cr,cw,cbe,ca,cd, er,ew,ebe,ea,ed, mrd | g, mreq,mwe,mbe,maddr,mwd, rv, crd, erd, wt, lg
    vecs[0]  = '{1,0, 1,0,4'hF,12'h010,32'h0, 0,0,4'h0,12'h000,32'h0, 32'h0,        2'b00,0,0,4'h0,12'h000,32'h0,        2'b00,32'h0,32'h0,4'd0,1};
    vecs[1]  = '{0,0, 1,0,4'hF,12'h010,32'h0, 0,0,4'h0,12'h000,32'h0, 32'h0,        2'b10,1,0,4'hF,12'h010,32'h0,        2'b00,32'h0,32'h0,4'd0,1};
    vecs[2]  = '{0,0, 0,0,4'h0,12'h000,32'h0, 0,0,4'h0,12'h000,32'h0, 32'hDEADBEEF, 2'b00,0,0,4'h0,12'h000,32'h0,        2'b10,32'hDEADBEEF,32'h0,4'd0,0};
    vecs[3]  = '{1,0, 0,0,4'h0,12'h000,32'h0, 0,0,4'h0,12'h000,32'h0, 32'h0,        2'b00,0,0,4'h0,12'h000,32'h0,        2'b00,32'h0,32'h0,4'd0,1};
    vecs[4]  = '{0,0, 1,0,4'hF,12'h020,32'h0, 1,0,4'hF,12'h030,32'h0, 32'h0,        2'b10,1,0,4'hF,12'h020,32'h0,        2'b00,32'h0,32'h0,4'd0,1};
    vecs[5]  = '{0,0, 1,0,4'hF,12'h020,32'h0, 1,0,4'hF,12'h030,32'h0, 32'h11111111, 2'b01,1,0,4'hF,12'h030,32'h0,        2'b10,32'h11111111,32'h0,4'd0,0};
    vecs[6]  = '{0,0, 1,0,4'hF,12'h020,32'h0, 1,0,4'hF,12'h030,32'h0, 32'h22222222, 2'b10,1,0,4'hF,12'h020,32'h0,        2'b01,32'h0,32'h22222222,4'd1,1};
    vecs[7]  = '{0,0, 1,0,4'hF,12'h020,32'h0, 1,0,4'hF,12'h030,32'h0, 32'h33333333, 2'b01,1,0,4'hF,12'h030,32'h0,        2'b10,32'h33333333,32'h0,4'd0,0};
    vecs[8]  = '{0,0, 0,0,4'h0,12'h000,32'h0, 0,0,4'h0,12'h000,32'h0, 32'h44444444, 2'b00,0,0,4'h0,12'h000,32'h0,        2'b01,32'h0,32'h44444444,4'd1,1};
    vecs[9]  = '{0,1, 1,0,4'hF,12'h040,32'h0, 1,1,4'hF,12'h3FF,32'h12345678, 32'h0, 2'b01,1,1,4'hF,12'h3FF,32'h12345678, 2'b00,32'h0,32'h0,4'd0,1};
    vecs[10] = '{0,1, 1,0,4'hF,12'h040,32'h0, 1,1,4'hF,12'h3FF,32'h12345678, 32'h0, 2'b01,1,1,4'hF,12'h3FF,32'h12345678, 2'b00,32'h0,32'h0,4'd0,1};
    vecs[11] = '{0,1, 0,0,4'h0,12'h000,32'h0, 1,1,4'h3,12'h005,32'hAABBCCDD, 32'h0, 2'b01,1,1,4'h3,12'h005,32'hAABBCCDD, 2'b00,32'h0,32'h0,4'd0,1};
    vecs[12] = '{0,0, 0,0,4'h0,12'h000,32'h0, 0,0,4'h0,12'h000,32'h0, 32'h55555555, 2'b00,0,0,4'h0,12'h000,32'h0,        2'b00,32'h0,32'h0,4'd0,1};
    vecs[13] = '{0,0, 0,0,4'h0,12'h000,32'h0, 1,0,4'hF,12'h077,32'h0, 32'h0,        2'b01,1,0,4'hF,12'h077,32'h0,        2'b00,32'h0,32'h0,4'd0,1};
    vecs[14] = '{1,0, 0,0,4'h0,12'h000,32'h0, 1,0,4'hF,12'h077,32'h0, 32'h66666666, 2'b00,0,0,4'h0,12'h000,32'h0,        2'b00,32'h0,32'h0,4'd0,1};
    vecs[15] = '{0,0, 0,0,4'h0,12'h000,32'h0, 0,0,4'h0,12'h000,32'h0, 32'h77777777, 2'b00,0,0,4'h0,12'h000,32'h0,        2'b00,32'h0,32'h0,4'd0,1};
    vecs[16] = '{0,0, 1,0,4'hF,12'h100,32'h0, 1,0,4'hF,12'h200,32'h0, 32'h0,        2'b10,1,0,4'hF,12'h100,32'h0,        2'b00,32'h0,32'h0,4'd0,1};
    vecs[17] = '{0,0, 0,0,4'h0,12'h000,32'h0, 0,0,4'h0,12'h000,32'h0, 32'h88888888, 2'b00,0,0,4'h0,12'h000,32'h0,        2'b10,32'h88888888,32'h0,4'd0,0};
    vecs[18] = '{0,0, 1,1,4'h5,12'h0AB,32'hCAFEF00D, 0,0,4'h0,12'h000,32'h0, 32'h0, 2'b10,1,1,4'h5,12'h0AB,32'hCAFEF00D, 2'b00,32'h0,32'h0,4'd0,0};
    vecs[19] = '{0,0, 0,0,4'h0,12'h000,32'h0, 0,0,4'h0,12'h000,32'h0, 32'h99999999, 2'b00,0,0,4'h0,12'h000,32'h0,        2'b00,32'h0,32'h0,4'd0,0};

    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);

    for (int i = 0; i < 20; i++) apply_vec(i);

    // Long program-mode contention: core starved, counter pinned at 0, ext reads return to ext.
    m_last = 1'b0; m_pend = 1'b0; m_id = 1'b0; m_wait = 4'd0;
    for (int i = 0; i < 20; i++) step($sformatf("prog%0d", i), 1'b1, 1'b1, 1'b1);

    // Drop program mode under contention: core wins at once, then strict alternation.
    for (int i = 0; i < 12; i++) step($sformatf("rr%0d", i), 1'b0, 1'b1, 1'b1);

    // Mixed single-requester and contended traffic.
    for (int i = 0; i < 16; i++) begin
      logic cr, er, pr;
      cr = 1'($urandom_range(0, 1));
      er = 1'($urandom_range(0, 1));
      pr = (i % 5 == 4);
      step($sformatf("mix%0d", i), pr, cr, er);
    end
    step("tail", 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
